// File: rtl/la_pkg.sv
// Shared definitions for the logic analyzer capture path and host register map.
package la_pkg;

    localparam int LA_WIDTH = 8;
    localparam int LA_AW    = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_POST = 2'd2,
        ST_DONE = 2'd3
    } la_state_e;

endpackage

// File: rtl/la_rate_gen.sv
// Programmable sample-rate strobe: TICK once every DIV+1 enabled clocks.
// DIV is compared live; lowering it below the running count lets the
// counter roll through 0xFFFF before the next tick.
module la_rate_gen (
    input  logic        CLKin,
    input  logic        RSTn,
    input  logic        EN,
    input  logic [15:0] DIV,
    output logic        TICK
);

    logic [15:0] rc_q, rc_d;

    assign TICK = EN && (rc_q == DIV);

    // Count while enabled, reload on tick, hold cleared while disabled
    always_comb begin
        rc_d = '0;
        if (EN && !TICK) rc_d = rc_q + 16'd1;
    end

    // Rate counter register
    always_ff @(posedge CLKin or negedge RSTn) begin
        if (!RSTn) rc_q <= '0;
        else       rc_q <= rc_d;
    end

endmodule

// File: rtl/la_capture_ctrl.sv
// Capture controller: sample PROBE on each rate tick, write it to the sample
// RAM, arm/trigger/post-count sequencing, completion reporting.
module la_capture_ctrl
    import la_pkg::*;
#(
    parameter int WIDTH = LA_WIDTH,
    parameter int AW    = LA_AW
) (
    input  logic             CLKin,
    input  logic             RSTn,
    input  logic [15:0]      DIV,
    input  logic             ARM,
    input  logic             ABORT,
    input  logic [AW-1:0]    POST_CNT,
    input  logic [WIDTH-1:0] TRIG_MASK,
    input  logic [WIDTH-1:0] TRIG_VAL,
    input  logic [WIDTH-1:0] PROBE,
    output logic             WE,
    output logic [AW-1:0]    WADDR,
    output logic [WIDTH-1:0] WDATA,
    output logic [AW-1:0]    TRIG_ADDR,
    output logic             WRAPPED,
    output logic             BUSY,
    output logic             DONE
);

    la_state_e        state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d, ptr_adv;
    logic [AW-1:0]    trig_addr_q, trig_addr_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic             we_q, we_d;
    logic             wrapped_q, wrapped_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             busy, tick, trig_hit;

    assign busy = (state_q == ST_WAIT) || (state_q == ST_POST);

    la_rate_gen u_rate (
        .CLKin (CLKin),
        .RSTn  (RSTn),
        .EN    (busy),
        .DIV   (DIV),
        .TICK  (tick)
    );

    // The pointer doubles as WADDR: it steps the cycle after each write, so
    // ptr_adv is the address the sample taken on this edge will land at.
    assign ptr_adv  = we_q ? ptr_q + AW'(1) : ptr_q;
    assign trig_hit = ((PROBE ^ TRIG_VAL) & TRIG_MASK) == '0;

    // Next-state, pointer, trigger and post-count logic; ABORT overrides all
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_adv;
        wrapped_d   = wrapped_q | (we_q && (&ptr_q));
        trig_addr_d = trig_addr_q;
        pc_d        = pc_q;
        we_d        = 1'b0;
        wdata_d     = wdata_q;
        if (ABORT) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (ARM) begin
                        state_d   = ST_WAIT;
                        ptr_d     = '0;
                        wrapped_d = 1'b0;
                        pc_d      = POST_CNT;
                    end
                end
                ST_WAIT: begin
                    if (tick) begin
                        we_d    = 1'b1;
                        wdata_d = PROBE;
                        if (trig_hit) begin
                            trig_addr_d = ptr_adv;
                            state_d     = (pc_q == '0) ? ST_DONE : ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (tick) begin
                        we_d    = 1'b1;
                        wdata_d = PROBE;
                        pc_d    = pc_q - AW'(1);
                        if (pc_q == AW'(1)) state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Capture state registers
    always_ff @(posedge CLKin or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            trig_addr_q <= '0;
            pc_q        <= '0;
            we_q        <= 1'b0;
            wrapped_q   <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            trig_addr_q <= trig_addr_d;
            pc_q        <= pc_d;
            we_q        <= we_d;
            wrapped_q   <= wrapped_d;
            wdata_q     <= wdata_d;
        end
    end

    assign WE        = we_q;
    assign WADDR     = ptr_q;
    assign WDATA     = wdata_q;
    assign TRIG_ADDR = trig_addr_q;
    assign WRAPPED   = wrapped_q;
    assign BUSY      = busy;
    assign DONE      = (state_q == ST_DONE);

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed bench for la_capture_ctrl (WIDTH=8, AW=4).
module tb_la_capture_ctrl;

    localparam int WIDTH = 8;
    localparam int AW    = 4;

    logic             CLKin, RSTn;
    logic [15:0]      DIV;
    logic             ARM, ABORT;
    logic [AW-1:0]    POST_CNT;
    logic [WIDTH-1:0] TRIG_MASK, TRIG_VAL, PROBE;
    logic             WE, WRAPPED, BUSY, DONE;
    logic [AW-1:0]    WADDR, TRIG_ADDR;
    logic [WIDTH-1:0] WDATA;

    int n_cmp = 0;
    int n_err = 0;

    la_capture_ctrl #(.WIDTH(WIDTH), .AW(AW)) dut (
        .CLKin     (CLKin),
        .RSTn      (RSTn),
        .DIV       (DIV),
        .ARM       (ARM),
        .ABORT     (ABORT),
        .POST_CNT  (POST_CNT),
        .TRIG_MASK (TRIG_MASK),
        .TRIG_VAL  (TRIG_VAL),
        .PROBE     (PROBE),
        .WE        (WE),
        .WADDR     (WADDR),
        .WDATA     (WDATA),
        .TRIG_ADDR (TRIG_ADDR),
        .WRAPPED   (WRAPPED),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    initial CLKin = 1'b0;
    always #5 CLKin = ~CLKin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLKin);
        #1;
    endtask

    task automatic arm();
        ARM = 1'b1;
        step();
        ARM = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".we"},   32'(WE), 0);
        chk({tag, ".wa"},   32'(WADDR), 0);
        chk({tag, ".wd"},   32'(WDATA), 0);
        chk({tag, ".ta"},   32'(TRIG_ADDR), 0);
        chk({tag, ".wrap"}, 32'(WRAPPED), 0);
        chk({tag, ".busy"}, 32'(BUSY), 0);
        chk({tag, ".done"}, 32'(DONE), 0);
    endtask

    initial begin
        int n, last;
        bit seen_done;
        RSTn = 1'b0; DIV = '0; ARM = 1'b0; ABORT = 1'b0; POST_CNT = '0;
        TRIG_MASK = '0; TRIG_VAL = '0; PROBE = '0;

        // reset state
        step(); step();
        chk_zero("rst");
        RSTn = 1'b1;
        step();
        chk_zero("idle");

        // T1: DIV=0, MASK=0, POST_CNT=3 -> four back-to-back writes 0..3
        DIV = 16'd0; POST_CNT = 4'd3; TRIG_MASK = 8'h00;
        arm();
        chk("t1.busy", 32'(BUSY), 1);
        chk("t1.we0", 32'(WE), 0);
        for (int i = 0; i < 4; i++) begin
            PROBE = 8'h30 + 8'(i);
            step();
            chk("t1.we",   32'(WE), 1);
            chk("t1.wa",   32'(WADDR), 32'(i));
            chk("t1.wd",   32'(WDATA), 32'h30 + 32'(i));
            chk("t1.done", 32'(DONE), (i == 3) ? 1 : 0);
            chk("t1.busy", 32'(BUSY), (i == 3) ? 0 : 1);
        end
        chk("t1.ta", 32'(TRIG_ADDR), 0);
        step();
        chk("t1.we_after", 32'(WE), 0);
        chk("t1.done_hold", 32'(DONE), 1);

        // T2: DIV=15, trigger on bit0 after five ticks, POST_CNT=2
        DIV = 16'd15; POST_CNT = 4'd2; TRIG_MASK = 8'h01; TRIG_VAL = 8'h01; PROBE = 8'h02;
        arm();
        n = 0; last = 0; seen_done = 1'b0;
        for (int cyc = 1; cyc <= 300 && !seen_done; cyc++) begin
            step();
            if (WE) begin
                chk("t2.wa", 32'(WADDR), 32'(n));
                chk("t2.wd", 32'(WDATA), (n < 5) ? 32'h02 : 32'h03);
                chk("t2.gap", 32'(cyc - last), 16);
                last = cyc;
                n++;
                if (n == 5) PROBE = 8'h03;
            end
            if (DONE) begin
                seen_done = 1'b1;
                chk("t2.we_at_done", 32'(WE), 1);
            end
        end
        chk("t2.done", 32'(seen_done), 1);
        chk("t2.nwr",  32'(n), 8);
        chk("t2.ta",   32'(TRIG_ADDR), 5);
        chk("t2.busy", 32'(BUSY), 0);

        // T3: AW=4 wrap, 20 untriggered ticks then trigger, POST_CNT=0
        DIV = 16'd0; POST_CNT = 4'd0; TRIG_MASK = 8'h80; TRIG_VAL = 8'h80; PROBE = 8'h00;
        arm();
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t3.we",   32'(WE), 1);
            chk("t3.wa",   32'(WADDR), 32'(i % 16));
            chk("t3.wrap", 32'(WRAPPED), (i >= 16) ? 1 : 0);
        end
        PROBE = 8'h80;
        step();
        chk("t3.trig_we", 32'(WE), 1);
        chk("t3.trig_wa", 32'(WADDR), 4);
        chk("t3.ta",      32'(TRIG_ADDR), 4);
        chk("t3.done",    32'(DONE), 1);
        chk("t3.busy",    32'(BUSY), 0);
        PROBE = 8'h00;
        step();
        chk("t3.we_after", 32'(WE), 0);
        chk("t3.wrap_hold", 32'(WRAPPED), 1);

        // T4: ABORT together with ARM during POST, then clean restart
        DIV = 16'd0; POST_CNT = 4'd10; TRIG_MASK = 8'hFF; TRIG_VAL = 8'h5A; PROBE = 8'h00;
        arm();
        chk("t4.wrap_clr", 32'(WRAPPED), 0);
        step(); step();
        PROBE = 8'h5A;
        step();
        chk("t4.trig_wa", 32'(WADDR), 2);
        chk("t4.ta", 32'(TRIG_ADDR), 2);
        PROBE = 8'h00;
        step();
        chk("t4.post_wa", 32'(WADDR), 3);
        ABORT = 1'b1; ARM = 1'b1;
        step();
        ABORT = 1'b0; ARM = 1'b0;
        chk("t4.ab_we",   32'(WE), 0);
        chk("t4.ab_busy", 32'(BUSY), 0);
        chk("t4.ab_done", 32'(DONE), 0);
        chk("t4.ab_ta",   32'(TRIG_ADDR), 2);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4.idle_we",   32'(WE), 0);
            chk("t4.idle_busy", 32'(BUSY), 0);
        end
        TRIG_MASK = 8'h00; POST_CNT = 4'd0;
        arm();
        chk("t4.re_busy", 32'(BUSY), 1);
        step();
        chk("t4.re_we",   32'(WE), 1);
        chk("t4.re_wa",   32'(WADDR), 0);
        chk("t4.re_done", 32'(DONE), 1);

        // T5: async reset during WAIT with a write in flight
        DIV = 16'd3; POST_CNT = 4'd1; TRIG_MASK = 8'hFF; TRIG_VAL = 8'hFF; PROBE = 8'h11;
        arm();
        for (int i = 0; i < 8; i++) step();
        chk("t5.pre_we", 32'(WE), 1);
        chk("t5.pre_wa", 32'(WADDR), 1);
        chk("t5.pre_wd", 32'(WDATA), 32'h11);
        #2 RSTn = 1'b0;
        #1 chk_zero("t5.async");
        #1 RSTn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5.post_rst_we", 32'(WE), 0);
            chk("t5.post_rst_busy", 32'(BUSY), 0);
        end
        arm();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5.early_we", 32'(WE), 0);
        end
        step();
        chk("t5.first_we", 32'(WE), 1);
        chk("t5.first_wa", 32'(WADDR), 0);

        // T6: ARM during WAIT is ignored (pointer and post count kept)
        ARM = 1'b1; POST_CNT = 4'd5;
        step();
        ARM = 1'b0;
        chk("t6.busy", 32'(BUSY), 1);
        step(); step(); step();
        chk("t6.we1", 32'(WE), 1);
        chk("t6.wa1", 32'(WADDR), 1);
        PROBE = 8'hFF;
        step(); step(); step(); step();
        chk("t6.trig_we", 32'(WE), 1);
        chk("t6.trig_wa", 32'(WADDR), 2);
        chk("t6.ta",      32'(TRIG_ADDR), 2);
        chk("t6.mid_done", 32'(DONE), 0);
        PROBE = 8'h00;
        step(); step(); step(); step();
        chk("t6.last_we", 32'(WE), 1);
        chk("t6.last_wa", 32'(WADDR), 3);
        chk("t6.done",    32'(DONE), 1);
        chk("t6.busy_end", 32'(BUSY), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
